// File: rtl/stage_sequencer.sv
// Purpose: five-stage instruction sequencer with prime cycle, single-step, halt and Stage-4 RAM-write wait.
// Latency: one stage per clock; Stage 4 may stretch up to WAIT_MAX+1 cycles waiting on Mem_Ready.
// Backpressure: Mem_Ready stalls Stage 4 for writing instructions only; Run/Step_Req gate entry to Fetch.
module stage_sequencer #(
    parameter logic [3:0] NOP_OPC  = 4'b0000,
    parameter logic [3:0] HALT_OPC = 4'b1111,
    parameter int         WAIT_MAX = 15
) (
    input  logic        Clock,
    input  logic        Reset_L,
    input  logic        Run,
    input  logic        Step_Mode,
    input  logic        Step_Req,
    input  logic [3:0]  Opcode,
    input  logic        WillWriteTo_Memory_H_RF_L,
    input  logic        Mem_Ready,
    output logic [2:0]  Stage,
    output logic        NOP_FLAG,
    output logic        Halted,
    output logic        Mem_Timeout,
    output logic [15:0] Instr_Count
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_PAUSED = 3'd6,
        S_HALTED = 3'd7
    } stage_t;

    localparam logic [3:0] WAIT_LIMIT = 4'(WAIT_MAX);

    stage_t     state;
    logic       primed;
    logic       halt_pend;
    logic [3:0] wait_cnt;

    // The stage code is the state register itself, so Stage is registered.
    assign Stage = state;

    // Sequencer state machine; every output is loaded here.
    always_ff @(posedge Clock or negedge Reset_L) begin
        if (!Reset_L) begin
            state       <= S_IDLE;
            primed      <= 1'b0;
            halt_pend   <= 1'b0;
            wait_cnt    <= 4'd0;
            NOP_FLAG    <= 1'b0;
            Halted      <= 1'b0;
            Mem_Timeout <= 1'b0;
            Instr_Count <= 16'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (Run) begin
                        if (!primed) begin
                            // Prime cycle: a bubble Write Back that loads the first instruction.
                            state    <= S_WB;
                            NOP_FLAG <= 1'b1;
                        end else begin
                            state    <= S_FETCH;
                            NOP_FLAG <= 1'b0;
                        end
                    end
                end
                S_FETCH: begin
                    // Opcode is only ever looked at on this edge.
                    NOP_FLAG  <= (Opcode == NOP_OPC) || (Opcode == HALT_OPC);
                    halt_pend <= (Opcode == HALT_OPC);
                    state     <= S_DECODE;
                end
                S_DECODE: begin
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    wait_cnt <= 4'd0;
                    state    <= S_MEM;
                end
                S_MEM: begin
                    if (!NOP_FLAG && WillWriteTo_Memory_H_RF_L && !Mem_Ready) begin
                        if (wait_cnt == WAIT_LIMIT) begin
                            // RAM never acknowledged: give up and flag it until reset.
                            Mem_Timeout <= 1'b1;
                            state       <= S_WB;
                        end else begin
                            wait_cnt <= wait_cnt + 4'd1;
                        end
                    end else begin
                        state <= S_WB;
                    end
                end
                S_WB: begin
                    NOP_FLAG <= 1'b0;
                    if (!primed) begin
                        // Leaving the prime cycle: not a real instruction, so no count.
                        primed <= 1'b1;
                        state  <= S_FETCH;
                    end else begin
                        Instr_Count <= Instr_Count + 16'd1;
                        if (halt_pend) begin
                            Halted <= 1'b1;
                            state  <= S_HALTED;
                        end else if (!Run) begin
                            state <= S_IDLE;
                        end else if (Step_Mode) begin
                            state <= S_PAUSED;
                        end else begin
                            state <= S_FETCH;
                        end
                    end
                end
                S_PAUSED: begin
                    if (!Run) begin
                        state <= S_IDLE;
                    end else if (!Step_Mode || Step_Req) begin
                        state <= S_FETCH;
                    end
                end
                S_HALTED: begin
                    // Only reset leaves this state.
                    state <= S_HALTED;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stage_sequencer.sv
// Purpose: directed-vector bench for stage_sequencer with hand-computed expectations.
// Latency: inputs change 1 ns after a rising edge; outputs are sampled at that same point.
// Backpressure: Mem_Ready is driven directly to exercise the Stage-4 wait and timeout.
module tb_stage_sequencer;

    logic        Clock = 1'b0;
    logic        Reset_L;
    logic        Run;
    logic        Step_Mode;
    logic        Step_Req;
    logic [3:0]  Opcode;
    logic        WillWriteTo_Memory_H_RF_L;
    logic        Mem_Ready;
    logic [2:0]  Stage;
    logic        NOP_FLAG;
    logic        Halted;
    logic        Mem_Timeout;
    logic [15:0] Instr_Count;

    int n_vec = 0;
    int n_bad = 0;

    stage_sequencer dut (
        .Clock                     (Clock),
        .Reset_L                   (Reset_L),
        .Run                       (Run),
        .Step_Mode                 (Step_Mode),
        .Step_Req                  (Step_Req),
        .Opcode                    (Opcode),
        .WillWriteTo_Memory_H_RF_L (WillWriteTo_Memory_H_RF_L),
        .Mem_Ready                 (Mem_Ready),
        .Stage                     (Stage),
        .NOP_FLAG                  (NOP_FLAG),
        .Halted                    (Halted),
        .Mem_Timeout               (Mem_Timeout),
        .Instr_Count               (Instr_Count)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // Stage and NOP_FLAG together, the most common check.
    task automatic chk_sn(input string tag, input logic [2:0] st, input logic nf);
        chk({tag, ".stage"}, 32'(Stage), 32'(st));
        chk({tag, ".nop"}, 32'(NOP_FLAG), 32'(nf));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".stage"}, 32'(Stage), 32'd0);
        chk({tag, ".nop"}, 32'(NOP_FLAG), 32'd0);
        chk({tag, ".halted"}, 32'(Halted), 32'd0);
        chk({tag, ".tmo"}, 32'(Mem_Timeout), 32'd0);
        chk({tag, ".cnt"}, 32'(Instr_Count), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 200000 ns");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset_L = 1'b0;
        Run = 1'b0;
        Step_Mode = 1'b0;
        Step_Req = 1'b0;
        Opcode = 4'h1;
        WillWriteTo_Memory_H_RF_L = 1'b0;
        Mem_Ready = 1'b0;
        tick();
        tick();
        chk_all_zero("reset");
        Reset_L = 1'b1;
        tick();
        chk("idle_hold", 32'(Stage), 32'd0);

        // Basic run: prime, then 1..5 and back to 1 with the count bumped.
        Run = 1'b1;
        tick(); chk_sn("prime", 3'd5, 1'b1);
        tick(); chk_sn("f1", 3'd1, 1'b0);
        chk("prime_nocount", 32'(Instr_Count), 32'd0);
        tick(); chk_sn("d1", 3'd2, 1'b0);
        tick(); chk_sn("e1", 3'd3, 1'b0);
        tick(); chk_sn("m1", 3'd4, 1'b0);
        tick(); chk_sn("w1", 3'd5, 1'b0);
        tick(); chk_sn("f2", 3'd1, 1'b0);
        chk("cnt1", 32'(Instr_Count), 32'd1);

        // NOP: flag high through 2..5, write with Mem_Ready low does not wait.
        Opcode = 4'h0;
        WillWriteTo_Memory_H_RF_L = 1'b1;
        tick(); chk_sn("nop_d", 3'd2, 1'b1);
        Opcode = 4'hF;  // must be ignored outside Fetch
        tick(); chk_sn("nop_e", 3'd3, 1'b1);
        tick(); chk_sn("nop_m", 3'd4, 1'b1);
        tick(); chk_sn("nop_w", 3'd5, 1'b1);
        tick(); chk_sn("nop_f", 3'd1, 1'b0);
        chk("cnt2", 32'(Instr_Count), 32'd2);
        chk("nop_nohalt", 32'(Halted), 32'd0);

        // Store with Mem_Ready low for three Stage-4 cycles: Stage 4 lasts 4 cycles.
        Opcode = 4'h2;
        tick(); tick(); tick();
        chk("st_enter", 32'(Stage), 32'd4);
        for (int i = 0; i < 3; i++) begin
            tick(); chk($sformatf("st_hold%0d", i), 32'(Stage), 32'd4);
        end
        Mem_Ready = 1'b1;
        tick(); chk("st_wb", 32'(Stage), 32'd5);
        chk("st_notmo", 32'(Mem_Timeout), 32'd0);
        Mem_Ready = 1'b0;
        tick(); chk("cnt3", 32'(Instr_Count), 32'd3);

        // Store that never completes: 16 cycles in Stage 4, then sticky timeout.
        Opcode = 4'h3;
        tick(); tick(); tick();
        chk("to_enter", 32'(Stage), 32'd4);
        for (int i = 0; i < 15; i++) begin
            tick();
            if (Stage !== 3'd4) chk($sformatf("to_hold%0d", i), 32'(Stage), 32'd4);
        end
        chk("to_hold_end", 32'(Stage), 32'd4);
        chk("to_pre", 32'(Mem_Timeout), 32'd0);
        tick(); chk("to_wb", 32'(Stage), 32'd5);
        chk("to_set", 32'(Mem_Timeout), 32'd1);
        tick(); chk("to_sticky", 32'(Mem_Timeout), 32'd1);
        chk("cnt4", 32'(Instr_Count), 32'd4);

        // Run dropped mid-instruction: finish it, then IDLE; restart without prime.
        Opcode = 4'h1;
        WillWriteTo_Memory_H_RF_L = 1'b0;
        tick(); Run = 1'b0;
        tick(); tick(); tick();
        chk("rd_wb", 32'(Stage), 32'd5);
        tick(); chk("rd_idle", 32'(Stage), 32'd0);
        chk("cnt5", 32'(Instr_Count), 32'd5);
        tick(); chk("rd_hold", 32'(Stage), 32'd0);
        Run = 1'b1;
        tick(); chk_sn("rd_noprime", 3'd1, 1'b0);

        // Step mode: Step_Req during Execute ignored, then pause after Write Back.
        Step_Mode = 1'b1;
        tick(); tick();
        chk("sm_e", 32'(Stage), 32'd3);
        Step_Req = 1'b1;
        tick(); Step_Req = 1'b0;
        chk("sm_m", 32'(Stage), 32'd4);
        tick(); tick();
        chk("sm_pause", 32'(Stage), 32'd6);
        chk("cnt6", 32'(Instr_Count), 32'd6);
        tick(); chk("sm_hold", 32'(Stage), 32'd6);
        Step_Req = 1'b1;
        tick(); Step_Req = 1'b0;
        chk("sm_step", 32'(Stage), 32'd1);
        tick(); tick(); tick(); tick();
        chk("sm_wb2", 32'(Stage), 32'd5);
        tick(); chk("sm_pause2", 32'(Stage), 32'd6);
        chk("cnt7", 32'(Instr_Count), 32'd7);
        Step_Mode = 1'b0;
        tick(); chk("sm_release", 32'(Stage), 32'd1);

        // Halt: flag set through 2..5, then Stage 7 regardless of inputs.
        Opcode = 4'hF;
        tick(); chk_sn("h_d", 3'd2, 1'b1);
        tick(); tick(); tick();
        chk_sn("h_w", 3'd5, 1'b1);
        tick(); chk("h_stage", 32'(Stage), 32'd7);
        chk("h_flag", 32'(Halted), 32'd1);
        chk("cnt8", 32'(Instr_Count), 32'd8);
        Run = 1'b0; Step_Req = 1'b1;
        tick(); chk("h_hold1", 32'(Stage), 32'd7);
        Run = 1'b1; Step_Req = 1'b0;
        tick(); chk("h_hold2", 32'(Stage), 32'd7);

        // Asynchronous reset out of HALTED, then re-prime.
        Reset_L = 1'b0;
        #2;
        chk_all_zero("rst_halt");
        Reset_L = 1'b1;
        tick(); chk_sn("rp_prime", 3'd5, 1'b1);
        tick(); chk("rp_f", 32'(Stage), 32'd1);

        // Reset in the middle of a Stage-4 wait.
        Opcode = 4'h2;
        WillWriteTo_Memory_H_RF_L = 1'b1;
        Mem_Ready = 1'b0;
        tick(); tick(); tick(); tick();
        chk("rw_wait", 32'(Stage), 32'd4);
        Reset_L = 1'b0;
        #2;
        chk_all_zero("rst_wait");
        Reset_L = 1'b1;
        tick(); chk_sn("rw_reprime", 3'd5, 1'b1);
        chk("rw_cnt", 32'(Instr_Count), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/stage_sequencer.md
STAGE_SEQUENCER -- requirements
Module: stage_sequencer

Interface
REQ-001 Ports SHALL be, in order: Clock in 1 (rising edge); Reset_L in 1 (asynchronous, active-low); Run in 1 (level, start/continue); Step_Mode in 1 (single-step enable); Step_Req in 1 (one-cycle pulse, advance one instruction); Opcode in 4 (IR[15:12], valid during Stage 1); WillWriteTo_Memory_H_RF_L in 1 (current instruction writes RAM); Mem_Ready in 1 (RAM write complete); Stage out 3 (current stage code); NOP_FLAG out 1; Halted out 1; Mem_Timeout out 1 (sticky); Instr_Count out 16.
REQ-002 Parameters SHALL be: NOP_OPC, default 4'b0000, opcode treated as no-operation; HALT_OPC, default 4'b1111, opcode that stops sequencing; WAIT_MAX, default 15, maximum Stage-4 wait cycles.
REQ-003 All outputs SHALL be registered; no combinational input-to-output path.

Function
REQ-004 Stage encoding SHALL be: 0 IDLE, 1 Fetch, 2 Decode, 3 Execute, 4 Memory, 5 Write Back, 6 PAUSED, 7 HALTED.
REQ-005 IDLE: while Run=0, hold; with Run=1, go to 5 if primed=0 (prime cycle), else go to 1.
REQ-006 Prime cycle: one Stage-5 cycle with NOP_FLAG=1 loads the first instruction; on exit primed SHALL set to 1 and the next stage SHALL be 1; Instr_Count SHALL NOT increment.
REQ-007 Normal sequence SHALL be 1->2->3->4->5, one cycle each except the Stage-4 wait (REQ-010).
REQ-008 At the 1->2 edge, NOP_FLAG SHALL load (Opcode==NOP_OPC)|(Opcode==HALT_OPC) and halt_pend SHALL load (Opcode==HALT_OPC); NOP_FLAG SHALL hold through Stage 5.
REQ-009 NOP_FLAG SHALL be 0 during Stage 1 of every non-prime instruction (cleared at the 5->1 edge).
REQ-010 Stage 4 with NOP_FLAG=0, WillWriteTo_Memory_H_RF_L=1 and Mem_Ready=0 SHALL hold Stage 4 and increment a 4-bit wait counter; advance to 5 when Mem_Ready=1 or when wait counter = WAIT_MAX; on timeout, Mem_Timeout SHALL set and remain 1 until reset.
REQ-011 Wait counter SHALL clear on every entry to Stage 4; Mem_Ready is ignored in all other stages and when WillWriteTo_Memory_H_RF_L=0.
REQ-012 Exit from Stage 5 (non-prime) SHALL increment Instr_Count (wraps 16'hFFFF->0) and select the next state by priority: halt_pend=1 -> 7; Run=0 -> 0; Step_Mode=1 -> 6; else -> 1.
REQ-013 HALTED (7): Halted=1, Stage held at 7 regardless of inputs; only Reset_L exits.
REQ-014 PAUSED (6): hold until Step_Req=1 while Run=1, then go to 1; Run=0 in PAUSED SHALL go to 0; Step_Mode cleared in PAUSED SHALL go to 1 on the next cycle.
REQ-015 Step_Req outside PAUSED SHALL be ignored (not queued).
REQ-016 Run deasserted mid-instruction SHALL NOT abort it; sampling occurs only per REQ-005, REQ-012 and REQ-014.
REQ-017 Opcode SHALL be sampled only at the 1->2 edge; changes elsewhere have no effect.

Reset
REQ-018 Reset_L=0 SHALL immediately force Stage=0, NOP_FLAG=0, Halted=0, Mem_Timeout=0, Instr_Count=0, primed=0, halt_pend=0, wait counter=0, including mid-instruction or mid-wait.
REQ-019 After Reset_L deasserts, the first Run=1 SHALL re-prime (REQ-005).

Verification
REQ-020 Reset, Run=1, Opcode=4'h1, WillWrite=0 -> Stage 0,5(NOP_FLAG=1),1,2,3,4,5,1...; Instr_Count=1 after first non-prime Stage 5.
REQ-021 Opcode=NOP_OPC at Stage 1 -> NOP_FLAG=1 during Stages 2-5, 0 at next Stage 1; WillWrite=1 with Mem_Ready=0 causes no wait.
REQ-022 Store (WillWrite=1), Mem_Ready low 3 cycles then high -> Stage 4 held 4 cycles, Mem_Timeout=0; Mem_Ready never high -> Stage 4 held 16 cycles, then Mem_Timeout=1.
REQ-023 Opcode=HALT_OPC -> Stages 2-5 with NOP_FLAG=1, then Stage 7, Halted=1; Run/Step_Req toggling leaves Stage 7 until Reset_L.
REQ-024 Step_Mode=1 -> Stage 6 after each Stage 5; Step_Req pulse -> exactly one instruction (1..5), back to 6; Step_Req during Stage 3 ignored.
REQ-025 Reset_L low during Stage 4 wait -> all outputs zero immediately; Run=1 afterwards -> prime Stage 5 again.
